// File: rtl/cpu0_trace_pkg.sv
// Shared types and header layout for the CPU0 trace dump transmitter.
// Frame: header word, latched PC, then one word per captured register.
package cpu0_trace_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    SEND
  } state_e;

  localparam logic [7:0] MAGIC_DEF = 8'hA5;
  localparam int NUM_REGS_DEF = 32;
  localparam int FRAME_WORDS = NUM_REGS_DEF + 2;

  localparam int TAG_LSB = 24;
  localparam int CNT_LSB = 16;
  localparam int SEQ_LSB = 0;

  function automatic logic [31:0] make_header(
    input logic [7:0]  tag,
    input logic [7:0]  cnt,
    input logic [15:0] seq
  );
    logic [31:0] h;
    h = '0;
    h[TAG_LSB +: 8] = tag;
    h[CNT_LSB +: 8] = cnt;
    h[SEQ_LSB +: 16] = seq;
    return h;
  endfunction

endpackage

// File: rtl/trace_frame_buf.sv
// Snapshot buffer: one synchronous write port, one combinational read port.
// Contents need no reset; every frame overwrites all entries before sending.
module trace_frame_buf #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/trace_dump_tx.sv
// Debug-trace transmitter: stalls the core, snapshots the register file,
// then streams a framed dump (header, PC, R0..Rn) over valid/ready.
module trace_dump_tx
  import cpu0_trace_pkg::*;
#(
  parameter int         NUM_REGS = NUM_REGS_DEF,
  parameter int         SEQ_W    = 16,
  parameter int         DROP_W   = 8,
  parameter logic [7:0] MAGIC    = MAGIC_DEF
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic                        snap_i,
  input  logic [31:0]                 pc_i,
  output logic                        hold_o,
  output logic [$clog2(NUM_REGS)-1:0] rf_addr_o,
  input  logic [31:0]                 rf_data_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [31:0]                 out_data_o,
  output logic                        out_last_o,
  output logic                        busy_o,
  output logic [DROP_W-1:0]           drop_cnt_o
);

  localparam int AW = $clog2(NUM_REGS);
  localparam int FW = NUM_REGS + 2;
  localparam int WW = $clog2(FW);

  state_e            state_q, state_d;
  logic [AW-1:0]     cap_q, cap_d;
  logic [WW-1:0]     w_q, w_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [31:0]       pc_q, pc_d;

  logic          req;
  logic          fire;
  logic          at_last;
  logic          buf_we;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;

  assign req     = snap_i & start_i;
  assign buf_we  = (state_q == CAPTURE);
  assign at_last = (w_q == WW'(FW - 1));
  assign rd_addr = AW'(w_q - WW'(2));

  trace_frame_buf #(
    .DEPTH (NUM_REGS),
    .AW    (AW)
  ) u_buf (
    .clk_i   (clk_i),
    .we_i    (buf_we),
    .waddr_i (cap_q),
    .wdata_i (rf_data_i),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cap_q   <= '0;
      w_q     <= '0;
      seq_q   <= '0;
      drop_q  <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      w_q     <= w_d;
      seq_q   <= seq_d;
      drop_q  <= drop_d;
      pc_q    <= pc_d;
    end
  end

  // Outputs decode from registered state so reset clears them at once.
  always_comb begin
    hold_o      = (state_q == CAPTURE);
    rf_addr_o   = (state_q == CAPTURE) ? cap_q : '0;
    out_valid_o = (state_q == SEND);
    out_last_o  = (state_q == SEND) && at_last;
    busy_o      = (state_q != IDLE);
    drop_cnt_o  = drop_q;
    out_data_o  = '0;
    if (state_q == SEND) begin
      if (w_q == '0)
        out_data_o = make_header(MAGIC, 8'(NUM_REGS), 16'(seq_q));
      else if (w_q == WW'(1))
        out_data_o = pc_q;
      else
        out_data_o = rd_data;
    end
  end

  assign fire = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    w_d     = w_q;
    seq_d   = seq_q;
    drop_d  = drop_q;
    pc_d    = pc_q;
    if (req && (state_q != IDLE) && (drop_q != '1))
      drop_d = drop_q + DROP_W'(1);
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = CAPTURE;
          pc_d    = pc_i;
          cap_d   = '0;
        end
      end
      CAPTURE: begin
        cap_d = cap_q + AW'(1);
        if (cap_q == AW'(NUM_REGS - 1)) begin
          state_d = SEND;
          cap_d   = '0;
          w_d     = '0;
        end
      end
      SEND: begin
        if (fire) begin
          w_d = w_q + WW'(1);
          if (at_last) begin
            state_d = IDLE;
            w_d     = '0;
            seq_d   = seq_q + SEQ_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_trace_dump_tx.sv
// Scoreboard bench for trace_dump_tx: bench-side register file model,
// expected frame words queued at the snap edge and popped on each transfer.
module tb_trace_dump_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        snap = 1'b0;
  logic        rdy = 1'b0;
  logic [31:0] pc_in = '0;
  logic        hold, valid, last, busy;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data, data;
  logic [7:0]  drop;

  logic [31:0] rf [32];
  logic [31:0] exp_q [$];
  logic [15:0] exp_seq = '0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign rf_data = rf[rf_addr];

  trace_dump_tx dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .snap_i      (snap),
    .pc_i        (pc_in),
    .hold_o      (hold),
    .rf_addr_o   (rf_addr),
    .rf_data_i   (rf_data),
    .out_valid_o (valid),
    .out_ready_i (rdy),
    .out_data_o  (data),
    .out_last_o  (last),
    .busy_o      (busy),
    .drop_cnt_o  (drop)
  );

  task automatic test_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({hold, valid, last, busy} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0000", {hold, valid, last, busy});
    end
    checks++;
    if (data !== 32'h0 || rf_addr !== 5'h0 || drop !== 8'h0) begin
      failures++;
      $display("FAIL reset_data got data=%h addr=%h drop=%h exp=0", data, rf_addr, drop);
    end
    @(negedge clk);
    rst = 1'b0;
    snap = 1'b0;
    exp_seq = '0;
    exp_q.delete();
  endtask

  task automatic run_frame(input logic [31:0] pc, input bit bp,
                           input int nsnap, input bit w5);
    int holds, got, sendc, lh, fv;
    bit stall;
    logic [31:0] pd, ex;
    logic pl;
    holds = 0; got = 0; sendc = 0; lh = -1; fv = -1;
    stall = 1'b0; pd = '0; pl = 1'b0;
    @(negedge clk);
    start = 1'b1; snap = 1'b1; pc_in = pc; rdy = 1'b0;
    @(posedge clk);
    if (w5) rf[5] = 32'h77;
    exp_q.push_back({8'hA5, 8'd32, exp_seq});
    exp_q.push_back(pc);
    for (int k = 0; k < 32; k++) exp_q.push_back(rf[k]);
    @(negedge clk);
    snap = 1'b0;
    pc_in = 32'hDEAD_BEEF;
    checks++;
    if (hold !== 1'b1) begin
      failures++;
      $display("FAIL hold_start got=%b exp=1", hold);
    end
    for (int c = 0; c < 400 && got < 34; c++) begin
      if (hold === 1'b1) begin
        checks++;
        if (rf_addr !== 5'(holds)) begin
          failures++;
          $display("FAIL rf_addr got=%0d exp=%0d", rf_addr, holds);
        end
        holds++;
        lh = c;
      end
      if (valid === 1'b1 && fv < 0) fv = c;
      rdy = bp ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      snap = (valid === 1'b1) &&
             ((sendc == 3 && nsnap > 0) || (sendc == 7 && nsnap > 1) ||
              (sendc == 11 && nsnap > 2));
      if (valid === 1'b1) sendc++;
      if (stall) begin
        checks++;
        if (data !== pd || last !== pl) begin
          failures++;
          $display("FAIL stall_stable got=%h/%b exp=%h/%b", data, last, pd, pl);
        end
      end
      if (valid === 1'b1 && rdy) begin
        ex = exp_q.pop_front();
        checks++;
        if (data !== ex) begin
          failures++;
          $display("FAIL word%0d got=%h exp=%h", got, data, ex);
        end
        checks++;
        if (last !== (exp_q.size() == 0)) begin
          failures++;
          $display("FAIL last%0d got=%b exp=%b", got, last, exp_q.size() == 0);
        end
        got++;
      end
      stall = (valid === 1'b1) && !rdy;
      pd = data;
      pl = last;
      @(negedge clk);
    end
    snap = 1'b0;
    checks++;
    if (got != 34) begin
      failures++;
      $display("FAIL word_count got=%0d exp=34", got);
    end
    checks++;
    if (holds != 32) begin
      failures++;
      $display("FAIL hold_cycles got=%0d exp=32", holds);
    end
    checks++;
    if (fv != lh + 1) begin
      failures++;
      $display("FAIL first_valid got=%0d exp=%0d", fv, lh + 1);
    end
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_after got=%b%b exp=00", busy, valid);
    end
    exp_q.delete();
    exp_seq++;
  endtask

  task automatic test_start_gate();
    @(negedge clk);
    start = 1'b0; snap = 1'b1;
    repeat (3) @(negedge clk);
    snap = 1'b0;
    checks++;
    if (busy !== 1'b0 || hold !== 1'b0 || drop !== 8'h0) begin
      failures++;
      $display("FAIL start_gate got=%b%b/%h exp=00/00", busy, hold, drop);
    end
  endtask

  task automatic test_basic();
    run_frame(32'h40, 1'b0, 0, 1'b0);
  endtask

  task automatic test_back_to_back_bp();
    run_frame(32'h1234, 1'b1, 0, 1'b0);
  endtask

  task automatic test_drops();
    test_reset();
    run_frame(32'h80, 1'b0, 3, 1'b0);
    checks++;
    if (drop !== 8'd3) begin
      failures++;
      $display("FAIL drop_cnt got=%0d exp=3", drop);
    end
    run_frame(32'h84, 1'b0, 0, 1'b0);
  endtask

  task automatic test_saturate();
    int words;
    bit done;
    test_reset();
    @(negedge clk);
    start = 1'b1; snap = 1'b1; rdy = 1'b0;
    for (int i = 0; i <= 300; i++) begin
      @(negedge clk);
      if (i == 10) begin
        checks++;
        if (drop !== 8'd10) begin
          failures++;
          $display("FAIL drop_mid got=%0d exp=10", drop);
        end
      end
    end
    snap = 1'b0;
    checks++;
    if (drop !== 8'd255) begin
      failures++;
      $display("FAIL drop_sat got=%0d exp=255", drop);
    end
    rdy = 1'b1;
    words = 0; done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      if (valid === 1'b1) words++;
      @(negedge clk);
      done = (busy === 1'b0);
    end
    checks++;
    if (words != 34 || !done) begin
      failures++;
      $display("FAIL sat_drain got=%0d/%b exp=34/1", words, done);
    end
    exp_seq++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; snap = 1'b1; rdy = 1'b1;
    @(negedge clk);
    snap = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (hold !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_hold got=%b exp=1", hold);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (hold !== 1'b0 || valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got=%b%b%b exp=000", hold, valid, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_seq = '0;
    exp_q.delete();
    run_frame(32'h99, 1'b0, 0, 1'b0);
  endtask

  task automatic test_r5_write();
    run_frame(32'h500, 1'b0, 0, 1'b1);
    rf[5] = 32'd15;
  endtask

  initial begin
    for (int k = 0; k < 32; k++) rf[k] = 32'(k * 3);
    test_reset();
    test_start_gate();
    test_basic();
    test_back_to_back_bp();
    test_drops();
    test_saturate();
    test_reset_mid();
    test_r5_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trace_dump_tx.md
Name: trace_dump_tx

Overview:
- Debug-trace transmitter inside CPU0.
- On a snapshot request from the core, it stalls the core and reads the register file through one read port into a local buffer.
- It then releases the core and streams a framed dump (header, PC, R0..R31) over a valid/ready word stream to an off-core sink or trace capture.
- It is the hardware source of the per-cycle PC/register dump that simulation benches print.

Parameters:
- NUM_REGS, 32, registers captured per frame; also the width source for rf_addr_o (clog2).
- SEQ_W, 16, frame sequence counter width; must be 16 (fixed header layout).
- DROP_W, 8, width of the saturating dropped-request counter.
- MAGIC, 8'hA5, header tag byte.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  trace enable; snapshot requests are ignored while low.
- snap_i  in  1  snapshot request, sampled each rising edge.
- pc_i  in  32  core PC, latched on the accepted snap edge.
- hold_o  out  1  stall to core; core must not write the register file or advance PC while high.
- rf_addr_o  out  5  register-file read address.
- rf_data_i  in  32  combinational read data for rf_addr_o.
- out_valid_o  out  1  stream word valid.
- out_ready_i  in  1  sink ready.
- out_data_o  out  32  stream word.
- out_last_o  out  1  high on the final word of a frame.
- busy_o  out  1  high in CAPTURE or SEND.
- drop_cnt_o  out  DROP_W  requests dropped while busy.

Behaviour:
- Reset (asynchronous, immediate): state IDLE, hold_o=0, out_valid_o=0, out_last_o=0, out_data_o=0, rf_addr_o=0, busy_o=0, seq=0, drop_cnt_o=0. Reset mid-frame abandons the frame and releases hold_o in the same instant.
- States: IDLE, CAPTURE, SEND.
- IDLE:
  - snap_i & start_i at edge E0: latch pc_i, go to CAPTURE, cap_idx=0.
  - snap_i while start_i=0: ignored and not counted.
- CAPTURE:
  - hold_o=1 (Moore output), rf_addr_o=cap_idx.
  - Each edge stores rf_data_i into buf[cap_idx] and increments cap_idx.
  - After the edge that stores index NUM_REGS-1, go to SEND.
  - hold_o is therefore high for exactly NUM_REGS cycles, starting the cycle after E0.
  - The snapshot reflects the register state after E0's write; a write performed at E0 itself is included.
- SEND:
  - hold_o=0, out_valid_o=1, word index w = 0..NUM_REGS+1.
  - w=0: header {MAGIC, 8'(NUM_REGS), seq}. w=1: latched PC. w=k+2: buf[k].
  - A word transfers on an edge with valid & ready; w then increments.
  - out_data_o and out_last_o stay stable while ready is low.
  - out_last_o=1 only at w=NUM_REGS+1.
  - On the last transfer: go to IDLE and set seq = seq+1, wrapping 16'hFFFF -> 0.
  - First valid word appears in the cycle after the CAPTURE->SEND edge.
  - Minimum frame: NUM_REGS capture cycles + NUM_REGS+2 send cycles.
- Drops: snap_i & start_i sampled while in CAPTURE or SEND increments drop_cnt_o, saturating at all-ones. The frame in progress is unaffected.
- start_i falling mid-frame: the frame completes normally.
- A snap in the same cycle as the final transfer counts as a drop. A new frame is accepted only from IDLE, so one idle cycle is required between frames.
- R0 is transmitted exactly as read; no forced zero.
- busy_o = (state != IDLE).

Decomposition:
- Package cpu0_trace_pkg holds:
  - state enum {IDLE, CAPTURE, SEND};
  - MAGIC default;
  - header field offsets: tag [31:24], count [23:16], seq [15:0];
  - FRAME_WORDS = NUM_REGS+2.
- Optional sub-module trace_frame_buf: NUM_REGS x 32 register array with one synchronous write port and one combinational read port. It is the only natural split; the FSM, counters and stream logic stay in trace_dump_tx.

Test Plan:
- Reset, then start=1 with regs Rk=k*3, pc=0x40, one-cycle snap. Required: hold_o high for exactly 32 cycles starting the cycle after snap; rf_addr_o goes 0..31; stream is 0xA5200000, 0x00000040, 0,3,...,93; out_last_o only on word 34.
- Back-pressure: ready toggles 1,0,0,1 repeatedly. Required: 34 words, none duplicated or skipped; data and last stable during stalls.
- Snap pulses on 3 separate cycles during SEND. Required: drop_cnt_o=3, frame unchanged. The next accepted frame's header has seq=1.
- 300 snaps while busy with DROP_W=8. Required: drop_cnt_o saturates at 255.
- Reset asserted at capture cycle 10. Required: hold_o, out_valid_o and busy_o go low with no clock edge. After release, the next frame has seq=0 and complete data.
- Core writes R5=0x77 at the snap edge E0. Required: the dumped R5 is 0x77; no register write occurs while hold_o=1.
